// File: rtl/l15_router_mem_rr.sv
// l15_router_mem_rr
// Router between one L2 port and NUM_CORES L1.5 ports, plus a small
// behavioural backing memory.
//
// Down path (registered, one-cycle latency): an accepted msg2 is turned into
// per-core messages. INV_FWD goes to every sharer in share_list. DATA_ACK
// goes to cache_owner, and every other core gets NODATA_ACK. Any other
// non-memory type goes to cache_owner only. LOAD_MEM/STORE_MEM are not
// forwarded. The memory FSM consumes them instead.
//
// Up path: msg1 and msg3 have independent round-robin arbiters with
// combinational select. While the memory FSM is presenting a response, it
// owns msg3 outright.
//
// Handshakes: a message moves when its type is not EMPTY and the matching
// ready is 1 in the same cycle. Senders hold type, data and tag steady until
// that cycle. On the down path, msg2_ready is low while the memory FSM is
// busy. On the up path, core_msgX_grant[i] marks the cycle in which core i's
// request moved to L2.
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   msg2_*, mesi_send             L2 -> router message, cache_owner/share_list
//                                 select the receiving cores
//   msg2_ready                    router can accept msg2 (memory FSM idle)
//   core_msg2_*, core_mesi_send   per-core down messages, core i at slice i
//   core_msg1_*, core_msg3_*      per-core up requests
//   core_msg1/3_grant             one-hot: that core's request was consumed
//   msg1_*, msg3_*                arbitrated up messages to L2, source=core
//   msg1_ready, msg3_ready        L2 accepts the up message
//   owner_err                     sticky: a unicast named a nonexistent core
//   mem_state                     memory FSM state, for observation only

`ifndef MSG_WIDTH
`define MSG_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef TAG_WIDTH
`define TAG_WIDTH 4
`endif
`ifndef MESI_WIDTH
`define MESI_WIDTH 2
`endif

module l15_router_mem_rr #(
  parameter int NUM_CORES = 4,
  parameter int MSG_W     = `MSG_WIDTH,
  parameter int DATA_W    = `DATA_WIDTH,
  parameter int TAG_W     = `TAG_WIDTH,
  parameter int MESI_W    = `MESI_WIDTH,
  parameter int MEM_LAT   = 2,
  localparam int SRC_W    = $clog2(NUM_CORES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [MSG_W-1:0]              msg2_type,
  input  logic [DATA_W-1:0]             msg2_data,
  input  logic [TAG_W-1:0]              msg2_tag,
  input  logic [MESI_W-1:0]             mesi_send,
  input  logic [SRC_W-1:0]              cache_owner,
  input  logic [NUM_CORES-1:0]          share_list,
  output logic                          msg2_ready,
  output logic [NUM_CORES*MSG_W-1:0]    core_msg2_type,
  output logic [NUM_CORES*DATA_W-1:0]   core_msg2_data,
  output logic [NUM_CORES*TAG_W-1:0]    core_msg2_tag,
  output logic [NUM_CORES*MESI_W-1:0]   core_mesi_send,
  input  logic [NUM_CORES*MSG_W-1:0]    core_msg1_type,
  input  logic [NUM_CORES*DATA_W-1:0]   core_msg1_data,
  input  logic [NUM_CORES*TAG_W-1:0]    core_msg1_tag,
  output logic [NUM_CORES-1:0]          core_msg1_grant,
  input  logic [NUM_CORES*MSG_W-1:0]    core_msg3_type,
  input  logic [NUM_CORES*DATA_W-1:0]   core_msg3_data,
  input  logic [NUM_CORES*TAG_W-1:0]    core_msg3_tag,
  output logic [NUM_CORES-1:0]          core_msg3_grant,
  output logic [MSG_W-1:0]              msg1_type,
  output logic [DATA_W-1:0]             msg1_data,
  output logic [TAG_W-1:0]              msg1_tag,
  output logic [SRC_W-1:0]              msg1_source,
  input  logic                          msg1_ready,
  output logic [MSG_W-1:0]              msg3_type,
  output logic [DATA_W-1:0]             msg3_data,
  output logic [TAG_W-1:0]              msg3_tag,
  output logic [SRC_W-1:0]              msg3_source,
  input  logic                          msg3_ready,
  output logic                          owner_err,
  output logic [1:0]                    mem_state
);

  // Message type encodings
  localparam logic [MSG_W-1:0] MSG_EMPTY         = MSG_W'(0);
  localparam logic [MSG_W-1:0] MSG_INV_FWD       = MSG_W'(1);
  localparam logic [MSG_W-1:0] MSG_DATA_ACK      = MSG_W'(2);
  localparam logic [MSG_W-1:0] MSG_NODATA_ACK    = MSG_W'(3);
  localparam logic [MSG_W-1:0] MSG_LOAD_MEM      = MSG_W'(4);
  localparam logic [MSG_W-1:0] MSG_STORE_MEM     = MSG_W'(5);
  localparam logic [MSG_W-1:0] MSG_LOAD_MEM_ACK  = MSG_W'(6);
  localparam logic [MSG_W-1:0] MSG_STORE_MEM_ACK = MSG_W'(7);

  localparam int MEM_DEPTH = 2 ** TAG_W;
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  // One extra bit so the owner range check is meaningful for any core count
  localparam logic [SRC_W:0] CORES_LIM = (SRC_W+1)'(NUM_CORES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } mem_state_t;

  mem_state_t              mem_st;
  logic [CNT_W-1:0]        mem_cnt;
  logic [MSG_W-1:0]        rsp_type;
  logic [DATA_W-1:0]       rsp_data;
  logic [TAG_W-1:0]        rsp_tag;
  logic [DATA_W-1:0]       mem [MEM_DEPTH];

  logic                    msg2_acc;
  logic                    msg2_is_mem;
  logic                    owner_ok;
  logic                    mem_resp;

  logic [SRC_W-1:0]        m1_ptr, m3_ptr;
  logic [SRC_W-1:0]        m1_win, m3_win;
  logic                    m1_found, m3_found;

  assign msg2_ready  = (mem_st == S_IDLE);
  assign msg2_acc    = (msg2_type != MSG_EMPTY) && msg2_ready;
  assign msg2_is_mem = (msg2_type == MSG_LOAD_MEM) || (msg2_type == MSG_STORE_MEM);
  assign owner_ok    = ({1'b0, cache_owner} < CORES_LIM);
  assign mem_resp    = (mem_st == S_RESP);
  assign mem_state   = mem_st;

  // ---------------------------------------------------------------------
  // Down path. Types clear every cycle, so each delivery is one cycle wide.
  // Data/tag/mesi are broadcast to every slice on a delivery. Only the
  // type slice marks which cores actually received the message.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        core_msg2_type[i*MSG_W +: MSG_W]   <= MSG_EMPTY;
        core_msg2_data[i*DATA_W +: DATA_W] <= '0;
        core_msg2_tag[i*TAG_W +: TAG_W]    <= '0;
        core_mesi_send[i*MESI_W +: MESI_W] <= '0;
      end
      owner_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        core_msg2_type[i*MSG_W +: MSG_W] <= MSG_EMPTY;
      end
      if (msg2_acc && !msg2_is_mem) begin
        for (int i = 0; i < NUM_CORES; i++) begin
          core_msg2_data[i*DATA_W +: DATA_W] <= msg2_data;
          core_msg2_tag[i*TAG_W +: TAG_W]    <= msg2_tag;
          core_mesi_send[i*MESI_W +: MESI_W] <= mesi_send;
        end
        if (msg2_type == MSG_INV_FWD) begin
          for (int i = 0; i < NUM_CORES; i++) begin
            if (share_list[i]) core_msg2_type[i*MSG_W +: MSG_W] <= MSG_INV_FWD;
          end
        end else if (!owner_ok) begin
          // Nothing is delivered for a nonexistent owner, not even NODATA_ACKs
          owner_err <= 1'b1;
        end else begin
          for (int i = 0; i < NUM_CORES; i++) begin
            if (SRC_W'(i) == cache_owner)
              core_msg2_type[i*MSG_W +: MSG_W] <= msg2_type;
            else if (msg2_type == MSG_DATA_ACK)
              core_msg2_type[i*MSG_W +: MSG_W] <= MSG_NODATA_ACK;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Memory FSM. The array is read or written at the accept edge. The
  // response waits out the latency and is held until msg3_ready.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_st   <= S_IDLE;
      mem_cnt  <= '0;
      rsp_type <= MSG_EMPTY;
      rsp_data <= '0;
      rsp_tag  <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      case (mem_st)
        S_IDLE: begin
          if (msg2_acc && msg2_is_mem) begin
            rsp_tag <= msg2_tag;
            if (msg2_type == MSG_STORE_MEM) begin
              mem[msg2_tag] <= msg2_data;
              rsp_data      <= msg2_data;
              rsp_type      <= MSG_STORE_MEM_ACK;
            end else begin
              rsp_data <= mem[msg2_tag];
              rsp_type <= MSG_LOAD_MEM_ACK;
            end
            if (MEM_LAT == 1) begin
              mem_st <= S_RESP;
            end else begin
              mem_st  <= S_WAIT;
              mem_cnt <= CNT_W'(MEM_LAT - 1);
            end
          end
        end
        S_WAIT: begin
          if (mem_cnt == CNT_W'(1)) mem_st <= S_RESP;
          else mem_cnt <= mem_cnt - 1'b1;
        end
        S_RESP: begin
          if (msg3_ready) mem_st <= S_IDLE;
        end
        default: mem_st <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Round-robin select: the first non-EMPTY request at or after the pointer
  // wins, wrapping from core NUM_CORES-1 back to core 0.
  // ---------------------------------------------------------------------
  function automatic int rr_idx(input logic [SRC_W-1:0] p, input int k);
    return (int'(p) + k) % NUM_CORES;
  endfunction

  function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] w);
    if (int'(w) == NUM_CORES - 1) return '0;
    else return w + 1'b1;
  endfunction

  always_comb begin
    m1_found = 1'b0;
    m1_win   = '0;
    m3_found = 1'b0;
    m3_win   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (!m1_found && core_msg1_type[rr_idx(m1_ptr, k)*MSG_W +: MSG_W] != MSG_EMPTY) begin
        m1_found = 1'b1;
        m1_win   = SRC_W'(rr_idx(m1_ptr, k));
      end
      if (!m3_found && core_msg3_type[rr_idx(m3_ptr, k)*MSG_W +: MSG_W] != MSG_EMPTY) begin
        m3_found = 1'b1;
        m3_win   = SRC_W'(rr_idx(m3_ptr, k));
      end
    end
  end

  always_comb begin
    msg1_type       = MSG_EMPTY;
    msg1_data       = '0;
    msg1_tag        = '0;
    msg1_source     = '0;
    core_msg1_grant = '0;
    if (m1_found) begin
      msg1_type   = core_msg1_type[int'(m1_win)*MSG_W +: MSG_W];
      msg1_data   = core_msg1_data[int'(m1_win)*DATA_W +: DATA_W];
      msg1_tag    = core_msg1_tag[int'(m1_win)*TAG_W +: TAG_W];
      msg1_source = m1_win;
      if (msg1_ready) core_msg1_grant[m1_win] = 1'b1;
    end
  end

  // The memory response pre-empts every core on msg3.
  always_comb begin
    msg3_type       = MSG_EMPTY;
    msg3_data       = '0;
    msg3_tag        = '0;
    msg3_source     = '0;
    core_msg3_grant = '0;
    if (mem_resp) begin
      msg3_type = rsp_type;
      msg3_data = rsp_data;
      msg3_tag  = rsp_tag;
    end else if (m3_found) begin
      msg3_type   = core_msg3_type[int'(m3_win)*MSG_W +: MSG_W];
      msg3_data   = core_msg3_data[int'(m3_win)*DATA_W +: DATA_W];
      msg3_tag    = core_msg3_tag[int'(m3_win)*TAG_W +: TAG_W];
      msg3_source = m3_win;
      if (msg3_ready) core_msg3_grant[m3_win] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m1_ptr <= '0;
      m3_ptr <= '0;
    end else begin
      if (m1_found && msg1_ready) m1_ptr <= next_idx(m1_win);
      if (!mem_resp && m3_found && msg3_ready) m3_ptr <= next_idx(m3_win);
    end
  end

endmodule
